// File: rtl/rotor_step_if.sv
// Rotor step controller bus: keyboard/load requests in, rotor positions and
// step/valid strobes out.
//   master : keyboard/switch front end (drives key, load, init positions)
//   slave  : rotor_step_controller (drives positions, strobes, busy)
interface rotor_step_if;
  logic       key_pressed;
  logic       load_positions;
  logic [4:0] init_left;
  logic [4:0] init_mid;
  logic [4:0] init_right;
  logic [6:0] pos_left;
  logic [6:0] pos_mid;
  logic [6:0] pos_right;
  logic       step_left;
  logic       step_mid;
  logic       step_right;
  logic       pos_valid;
  logic       busy;

  modport master (
    output key_pressed, load_positions, init_left, init_mid, init_right,
    input  pos_left, pos_mid, pos_right, step_left, step_mid, step_right,
           pos_valid, busy
  );

  modport slave (
    input  key_pressed, load_positions, init_left, init_mid, init_right,
    output pos_left, pos_mid, pos_right, step_left, step_mid, step_right,
           pos_valid, busy
  );
endinterface

// File: rtl/rotor_step_controller.sv
// Three-rotor Enigma stepping controller. Each key press (rising edge) moves
// the rotor stack exactly one mechanical step, with right->middle notch carry
// and the middle-rotor double-step. Positions can be loaded while
// load_positions is held.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : rotor_step_if.slave (key/load/init in; pos_*, step_*,
//           pos_valid, busy out)
module rotor_step_controller #(
  parameter int unsigned NOTCH_RIGHT = 21,
  parameter int unsigned NOTCH_MID   = 4,
  parameter int unsigned END_VALUE   = 25
) (
  input  logic         clk,
  input  logic         reset,
  rotor_step_if.slave  bus
);

  localparam logic [4:0] NR = 5'(NOTCH_RIGHT);
  localparam logic [4:0] NM = 5'(NOTCH_MID);
  localparam logic [4:0] EV = 5'(END_VALUE);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

  state_t     state;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       key_q;
  logic       key_edge;
  logic       mid_at_notch;
  logic       mid_moves;

  function automatic logic [4:0] advance(input logic [4:0] p);
    return (p == EV) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range load requests fall back to position 0.
  function automatic logic [4:0] sanitize(input logic [4:0] p);
    return (p > EV) ? 5'd0 : p;
  endfunction

  assign key_edge     = bus.key_pressed & ~key_q;
  assign mid_at_notch = (pos_m == NM);
  // Middle rotor moves on right-rotor carry, or by itself when sitting on its
  // own notch (the double-step).
  assign mid_moves    = (pos_r == NR) | mid_at_notch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pos_l <= 5'd0;
      pos_m <= 5'd0;
      pos_r <= 5'd0;
      key_q <= 1'b0;
    end else begin
      // Sampled in every state so a key held through STEP/DONE never
      // produces a second edge.
      key_q <= bus.key_pressed;
      case (state)
        IDLE: begin
          if (bus.load_positions) state <= LOAD;
          else if (key_edge)      state <= STEP;
        end
        LOAD: begin
          pos_l <= sanitize(bus.init_left);
          pos_m <= sanitize(bus.init_mid);
          pos_r <= sanitize(bus.init_right);
          if (!bus.load_positions) state <= IDLE;
        end
        STEP: begin
          pos_r <= advance(pos_r);
          if (mid_moves)    pos_m <= advance(pos_m);
          if (mid_at_notch) pos_l <= advance(pos_l);
          state <= DONE;
        end
        DONE: state <= bus.load_positions ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decodes of the state register and the registered positions.
  assign bus.step_right = (state == STEP);
  assign bus.step_mid   = (state == STEP) & mid_moves;
  assign bus.step_left  = (state == STEP) & mid_at_notch;
  assign bus.pos_valid  = (state == DONE);
  assign bus.busy       = (state == STEP) | (state == DONE);

  assign bus.pos_left  = {2'b00, pos_l};
  assign bus.pos_mid   = {2'b00, pos_m};
  assign bus.pos_right = {2'b00, pos_r};

endmodule

// File: tb/tb_rotor_step_controller.sv
// Directed bench for rotor_step_controller. Expected positions for every
// accepted press are queued when the press is driven and compared when
// pos_valid appears; step pulses are tallied and checked per press.
module tb_rotor_step_controller;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  rotor_step_if bus ();

  rotor_step_controller #(
    .NOTCH_RIGHT(21), .NOTCH_MID(4), .END_VALUE(25)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  int cnt_l = 0, cnt_m = 0, cnt_r = 0, cnt_all = 0, cnt_valid = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard / strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.step_left)  cnt_l++;
      if (bus.step_mid)   cnt_m++;
      if (bus.step_right) cnt_r++;
      if (bus.step_left && bus.step_mid && bus.step_right) cnt_all++;
      if (bus.pos_valid) begin
        cnt_valid++;
        if (exp_q.size() == 0) chk("unexpected_pos_valid", 1, 0);
        else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          chk("valid_pos", int'({bus.pos_left, bus.pos_mid, bus.pos_right}), int'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pos(input string tag, input int l, input int m, input int r);
    @(negedge clk);
    chk({tag, "_left"},  int'(bus.pos_left),  l);
    chk({tag, "_mid"},   int'(bus.pos_mid),   m);
    chk({tag, "_right"}, int'(bus.pos_right), r);
    tick();
  endtask

  // One press held for 'hold' cycles; checks step pulse tallies.
  task automatic press(input string tag, input int hold,
                       input int l, input int m, input int r,
                       input int sl, input int sm, input int sr, input int sall);
    int l0, m0, r0, a0, v0;
    l0 = cnt_l; m0 = cnt_m; r0 = cnt_r; a0 = cnt_all; v0 = cnt_valid;
    exp_q.push_back({7'(l), 7'(m), 7'(r)});
    bus.key_pressed = 1'b1;
    repeat (hold) tick();
    bus.key_pressed = 1'b0;
    repeat (3) tick();
    chk({tag, "_step_left"},  cnt_l - l0, sl);
    chk({tag, "_step_mid"},   cnt_m - m0, sm);
    chk({tag, "_step_right"}, cnt_r - r0, sr);
    chk({tag, "_step_all3"},  cnt_all - a0, sall);
    chk({tag, "_valid_cnt"},  cnt_valid - v0, 1);
  endtask

  task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    bus.init_left = l; bus.init_mid = m; bus.init_right = r;
    bus.load_positions = 1'b1;
    repeat (2) tick();
    bus.load_positions = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int v0, r0;
    reset = 1'b1;
    bus.key_pressed = 1'b1;
    bus.load_positions = 1'b1;
    bus.init_left = 5'd9; bus.init_mid = 5'd9; bus.init_right = 5'd9;

    // Reset held with key and load active.
    tick();
    @(negedge clk);
    chk("rst_pos", int'({bus.pos_left, bus.pos_mid, bus.pos_right}), 0);
    chk("rst_steps", int'({bus.step_left, bus.step_mid, bus.step_right}), 0);
    chk("rst_valid", int'(bus.pos_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    tick();
    reset = 1'b0;
    bus.key_pressed = 1'b0;
    bus.load_positions = 1'b0;
    repeat (2) tick();
    chk_pos("post_rst", 0, 0, 0);

    // Double-step sequence.
    load(5'd0, 5'd3, 5'd20);
    chk_pos("load_0_3_20", 0, 3, 20);
    press("ds1", 2, 0, 3, 21, 0, 0, 1, 0);
    press("ds2", 2, 0, 4, 22, 0, 1, 1, 0);
    press("ds3", 2, 1, 5, 23, 1, 1, 1, 1);

    // Wrap and out-of-range load.
    load(5'd25, 5'd25, 5'd25);
    press("wrap", 2, 25, 25, 0, 0, 0, 1, 0);
    load(5'd3, 5'd26, 5'd30);
    chk_pos("range", 3, 0, 0);

    // Held key gives one step.
    press("held", 10, 3, 0, 1, 0, 0, 1, 0);

    // Key toggled during DONE is dropped.
    r0 = cnt_r; v0 = cnt_valid;
    exp_q.push_back({7'd3, 7'd0, 7'd2});
    bus.key_pressed = 1'b1; tick();      // STEP
    bus.key_pressed = 1'b0; tick();      // DONE
    bus.key_pressed = 1'b1; repeat (4) tick();
    bus.key_pressed = 1'b0; repeat (3) tick();
    chk("done_toggle_steps", cnt_r - r0, 1);
    chk("done_toggle_valid", cnt_valid - v0, 1);
    chk_pos("done_toggle", 3, 0, 2);

    // Load and key edge in the same cycle: load wins.
    r0 = cnt_r; v0 = cnt_valid;
    bus.init_left = 5'd7; bus.init_mid = 5'd8; bus.init_right = 5'd9;
    bus.key_pressed = 1'b1; bus.load_positions = 1'b1;
    repeat (2) tick();
    bus.load_positions = 1'b0;
    repeat (3) tick();
    bus.key_pressed = 1'b0; tick();
    chk("load_vs_key_steps", cnt_r - r0, 0);
    chk("load_vs_key_valid", cnt_valid - v0, 0);
    chk_pos("load_vs_key", 7, 8, 9);

    // Load raised during STEP: step completes, then load.
    r0 = cnt_r;
    exp_q.push_back({7'd7, 7'd8, 7'd10});
    bus.init_left = 5'd10; bus.init_mid = 5'd11; bus.init_right = 5'd12;
    bus.key_pressed = 1'b1; tick();      // STEP
    bus.load_positions = 1'b1; bus.key_pressed = 1'b0;
    repeat (3) tick();                   // DONE, LOAD, LOAD
    bus.load_positions = 1'b0;
    repeat (2) tick();
    chk("load_in_step_steps", cnt_r - r0, 1);
    chk_pos("load_in_step", 10, 11, 12);

    // Reset during STEP: no partial step, no pos_valid.
    v0 = cnt_valid;
    bus.key_pressed = 1'b1; tick();      // STEP
    reset = 1'b1; bus.key_pressed = 1'b0; tick();
    @(negedge clk);
    chk("rst_mid_busy", int'(bus.busy), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_mid_valid", cnt_valid - v0, 0);
    chk_pos("rst_mid", 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
